// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants and types for the instruction-fetch stage.
//   INSTR_BYTES   : size of one instruction word in bytes
//   NOP_INSTR     : encoding of "addi x0, x0, 0", held in the IF/ID register
//                   while it contains no valid instruction
//   fetch_state_t : BOOT (one idle cycle after reset), RUN, FAULT (sticky)
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counter.sv
// -----------------------------------------------------------------------------
// fetch_perf_counter
// 32-bit event counter that saturates at all-ones instead of wrapping.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset, clears the count
//   en    : count one event this cycle
//   count : current count
// -----------------------------------------------------------------------------
module fetch_perf_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] count
);

    logic [31:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= 32'd0;
        end else if (en && (count_reg != 32'hFFFF_FFFF)) begin
            count_reg <= count_reg + 32'd1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, reads the combinational instruction
// memory and registers {pc, instruction} into the IF/ID register with a
// valid/ready handshake toward decode. Redirects from execute take priority
// over everything; misaligned or out-of-range PCs move the stage to a sticky
// FAULT state that only reset or a legal redirect leaves.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   imem_addr/imem_instr : byte address out, little-endian word back (same cycle)
//   redirect_valid/_pc   : PC change request from execute
//   out_valid/out_ready  : IF/ID handshake toward decode
//   out_pc/out_pc_plus4/out_instr : held instruction and its PC (+4 for links)
//   fetch_fault/fault_pc : stage is in FAULT, and the offending address
//   perf_fetched/perf_stall : saturating event counters, present only when
//                          the macro FETCH_PERF_CNT_EN is defined
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 109
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic [31:0] out_instr,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam logic [32:0] MEM_LAST  = 33'(MEM_BYTES - 1);
    localparam logic [32:0] WORD_TAIL = 33'(INSTR_BYTES - 1);
    localparam logic [31:0] PC_STEP   = 32'(INSTR_BYTES);

    // A word fetch is legal when aligned and its last byte lies inside memory.
    // The sum is formed in 33 bits so addresses near 2^32 do not wrap into range.
    function automatic logic pc_legal(input logic [31:0] pc);
        logic [32:0] last_byte;
        last_byte = {1'b0, pc} + WORD_TAIL;
        return (pc[1:0] == 2'b00) && (last_byte <= MEM_LAST);
    endfunction

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic         out_valid_reg, out_valid_next;
    logic [31:0]  out_pc_reg, out_pc_next;
    logic [31:0]  out_pc_plus4_reg, out_pc_plus4_next;
    logic [31:0]  out_instr_reg, out_instr_next;
    logic [31:0]  fault_pc_reg, fault_pc_next;
    logic         fetch_en;
    logic         capture;

    assign fetch_en = (state_reg == RUN) && !redirect_valid &&
                      (!out_valid_reg || out_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= BOOT;
            pc_reg           <= RESET_PC;
            out_valid_reg    <= 1'b0;
            out_pc_reg       <= 32'd0;
            out_pc_plus4_reg <= 32'd4;
            out_instr_reg    <= NOP_INSTR;
            fault_pc_reg     <= 32'd0;
        end else begin
            state_reg        <= state_next;
            pc_reg           <= pc_next;
            out_valid_reg    <= out_valid_next;
            out_pc_reg       <= out_pc_next;
            out_pc_plus4_reg <= out_pc_plus4_next;
            out_instr_reg    <= out_instr_next;
            fault_pc_reg     <= fault_pc_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        pc_next           = pc_reg;
        out_valid_next    = out_valid_reg;
        out_pc_next       = out_pc_reg;
        out_pc_plus4_next = out_pc_plus4_reg;
        out_instr_next    = out_instr_reg;
        fault_pc_next     = fault_pc_reg;
        capture           = 1'b0;

        if (redirect_valid) begin
            // Squash whatever is held; the new stream starts at redirect_pc.
            out_valid_next = 1'b0;
            pc_next        = redirect_pc;
            if (pc_legal(redirect_pc)) begin
                state_next = RUN;
            end else begin
                state_next    = FAULT;
                fault_pc_next = redirect_pc;
            end
        end else begin
            // An accepted word drains; a capture below refills the register.
            if (out_valid_reg && out_ready) begin
                out_valid_next = 1'b0;
            end
            case (state_reg)
                BOOT: state_next = RUN;
                RUN: begin
                    if (fetch_en) begin
                        if (pc_legal(pc_reg)) begin
                            capture = 1'b1;
                        end else begin
                            state_next    = FAULT;
                            fault_pc_next = pc_reg;
                        end
                    end
                end
                FAULT: state_next = FAULT;
                default: state_next = BOOT;
            endcase
        end

        if (capture) begin
            out_valid_next    = 1'b1;
            out_pc_next       = pc_reg;
            out_pc_plus4_next = pc_reg + PC_STEP;
            out_instr_next    = imem_instr;
            pc_next           = pc_reg + PC_STEP;
        end
    end

    assign imem_addr    = pc_reg;
    assign out_valid    = out_valid_reg;
    assign out_pc       = out_pc_reg;
    assign out_pc_plus4 = out_pc_plus4_reg;
    assign out_instr    = out_instr_reg;
    assign fetch_fault  = (state_reg == FAULT);
    assign fault_pc     = fault_pc_reg;

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_counter u_perf_fetched (
        .clk   (clk),
        .reset (reset),
        .en    (capture),
        .count (perf_fetched)
    );

    fetch_perf_counter u_perf_stall (
        .clk   (clk),
        .reset (reset),
        .en    (out_valid_reg && !out_ready),
        .count (perf_stall)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed testbench for fetch_stage with a 109-byte instruction memory model.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_instr;
    logic        fetch_fault;
    logic [31:0] fault_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Word contents of the instruction memory (words at 0..104 are legal).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h0073_2823;
            32'd4:   return 32'h8001_00b3;
            32'd8:   return 32'h0020_9133;
            32'd12:  return 32'h00c5_4ab3;
            32'd68:  return 32'h0041_0063;
            default: return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    assign imem_instr = (imem_addr <= 32'd104) ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .MEM_BYTES (109)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .out_instr      (out_instr),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b1;
        tick(); tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_checks++; if (out_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %h want 0", out_pc); end
        n_checks++; if (out_pc_plus4 !== 32'd4) begin n_fail++; $display("FAIL reset_pc4 got %h want 4", out_pc_plus4); end
        n_checks++; if (out_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr got %h want 00000013", out_instr); end
        n_checks++; if (fetch_fault !== 1'b0 || fault_pc !== 32'd0) begin n_fail++; $display("FAIL reset_fault got %b/%h want 0/0", fetch_fault, fault_pc); end
        n_checks++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr got %h want 0", imem_addr); end
        $display("reset: out_valid=%b out_instr=%h", out_valid, out_instr);
    endtask

    task automatic test_boot_sequence();
        logic [31:0] exp_instr [3];
        exp_instr[0] = 32'h0073_2823; exp_instr[1] = 32'h8001_00b3; exp_instr[2] = 32'h0020_9133;
        reset = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL boot_idle got %b want 0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("fetch: out_pc=%h out_instr=%h", out_pc, out_instr);
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== exp_instr[i] ||
                out_pc_plus4 !== 32'(4 * i + 4)) begin
                n_fail++;
                $display("FAIL seq_%0d got v=%b pc=%h pc4=%h instr=%h want v=1 pc=%h pc4=%h instr=%h",
                         i, out_valid, out_pc, out_pc_plus4, out_instr, 32'(4 * i), 32'(4 * i + 4), exp_instr[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("stall: out_pc=%h imem_addr=%h", out_pc, imem_addr);
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'd8 || out_instr !== 32'h0020_9133 || imem_addr !== 32'd12) begin
                n_fail++;
                $display("FAIL stall_%0d got v=%b pc=%h instr=%h addr=%h want v=1 pc=8 instr=00209133 addr=c",
                         i, out_valid, out_pc, out_instr, imem_addr);
            end
        end
        out_ready = 1'b1;
        tick();
        $display("release: out_pc=%h out_instr=%h", out_pc, out_instr);
        n_checks++; if (out_pc !== 32'd12 || out_instr !== 32'h00c5_4ab3 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL release got v=%b pc=%h instr=%h want v=1 pc=c instr=00c54ab3", out_valid, out_pc, out_instr); end
    endtask

    task automatic test_redirect();
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd68;
        tick();
        $display("redirect: out_valid=%b imem_addr=%h", out_valid, imem_addr);
        n_checks++; if (out_valid !== 1'b0 || imem_addr !== 32'd68) begin
            n_fail++; $display("FAIL redirect_squash got v=%b addr=%h want v=0 addr=44", out_valid, imem_addr); end
        redirect_valid = 1'b0; out_ready = 1'b1;
        tick();
        $display("fetch: out_pc=%h out_instr=%h", out_pc, out_instr);
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'd68 || out_instr !== 32'h0041_0063 || out_pc_plus4 !== 32'd72) begin
            n_fail++; $display("FAIL redirect_target got v=%b pc=%h pc4=%h instr=%h want v=1 pc=44 pc4=48 instr=00410063",
                               out_valid, out_pc, out_pc_plus4, out_instr); end
    endtask

    task automatic test_fault_end();
        logic [31:0] exp_pc;
        logic [31:0] last_pc;
        int          budget;
        exp_pc  = 32'd72;
        last_pc = 32'd68;
        budget  = 30;
        out_ready = 1'b1;
        while (!fetch_fault && budget > 0) begin
            tick();
            budget--;
            if (out_valid) begin
                $display("fetch: out_pc=%h out_instr=%h", out_pc, out_instr);
                n_checks++; if (out_pc !== exp_pc || out_instr !== mem_word(exp_pc)) begin
                    n_fail++; $display("FAIL run_word got pc=%h instr=%h want pc=%h instr=%h",
                                       out_pc, out_instr, exp_pc, mem_word(exp_pc)); end
                last_pc = out_pc;
                exp_pc  = exp_pc + 32'd4;
            end
        end
        $display("fault: fetch_fault=%b fault_pc=%h", fetch_fault, fault_pc);
        n_checks++; if (budget == 0) begin n_fail++; $display("FAIL fault_timeout got no fault want fault at 6c"); end
        n_checks++; if (last_pc !== 32'd104) begin n_fail++; $display("FAIL last_word got %h want 68", last_pc); end
        n_checks++; if (fetch_fault !== 1'b1 || fault_pc !== 32'd108 || out_valid !== 1'b0 || imem_addr !== 32'd108) begin
            n_fail++; $display("FAIL fault_end got f=%b fpc=%h v=%b addr=%h want f=1 fpc=6c v=0 addr=6c",
                               fetch_fault, fault_pc, out_valid, imem_addr); end
        tick();
        n_checks++; if (fetch_fault !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL fault_sticky got f=%b v=%b want f=1 v=0", fetch_fault, out_valid); end
    endtask

    task automatic test_fault_recovery();
        redirect_valid = 1'b1; redirect_pc = 32'd6;
        tick();
        $display("redirect 6: fetch_fault=%b fault_pc=%h", fetch_fault, fault_pc);
        n_checks++; if (fetch_fault !== 1'b1 || fault_pc !== 32'd6) begin
            n_fail++; $display("FAIL misalign_redirect got f=%b fpc=%h want f=1 fpc=6", fetch_fault, fault_pc); end
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        n_checks++; if (fetch_fault !== 1'b1 || fault_pc !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_redirect got f=%b fpc=%h want f=1 fpc=fffffffc", fetch_fault, fault_pc); end
        redirect_pc = 32'd0;
        tick();
        $display("redirect 0: fetch_fault=%b out_valid=%b", fetch_fault, out_valid);
        n_checks++; if (fetch_fault !== 1'b0 || out_valid !== 1'b0 || imem_addr !== 32'd0) begin
            n_fail++; $display("FAIL recover got f=%b v=%b addr=%h want f=0 v=0 addr=0", fetch_fault, out_valid, imem_addr); end
        redirect_valid = 1'b0;
        tick();
        $display("fetch: out_pc=%h out_instr=%h", out_pc, out_instr);
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instr !== 32'h0073_2823) begin
            n_fail++; $display("FAIL recover_fetch got v=%b pc=%h instr=%h want v=1 pc=0 instr=00732823", out_valid, out_pc, out_instr); end
        // Highest legal word is accepted as a redirect target.
        redirect_valid = 1'b1; redirect_pc = 32'd104;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_checks++; if (fetch_fault !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'd104) begin
            n_fail++; $display("FAIL edge_target got f=%b v=%b pc=%h want f=0 v=1 pc=68", fetch_fault, out_valid, out_pc); end
    endtask

    task automatic test_boot_redirect_and_midreset();
        // Hold a word with backpressure, then reset: the held output is discarded.
        out_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0000_0013 || imem_addr !== 32'd0) begin
            n_fail++; $display("FAIL mid_reset got v=%b instr=%h addr=%h want v=0 instr=00000013 addr=0", out_valid, out_instr, imem_addr); end
        // Redirect on the first BOOT cycle skips the idle cycle.
        reset = 1'b0; out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd8;
        tick();
        redirect_valid = 1'b0;
        tick();
        $display("boot redirect: out_pc=%h out_instr=%h", out_pc, out_instr);
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'd8 || out_instr !== 32'h0020_9133) begin
            n_fail++; $display("FAIL boot_redirect got v=%b pc=%h instr=%h want v=1 pc=8 instr=00209133", out_valid, out_pc, out_instr); end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_counters();
        reset = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) tick();
        out_ready = 1'b0;
        tick(); tick();
        $display("perf: fetched=%0d stall=%0d", perf_fetched, perf_stall);
        n_checks++; if (perf_fetched !== 32'd5 || perf_stall !== 32'd2) begin
            n_fail++; $display("FAIL perf_count got %0d/%0d want 5/2", perf_fetched, perf_stall); end
        reset = 1'b1;
        tick();
        n_checks++; if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
            n_fail++; $display("FAIL perf_reset got %0d/%0d want 0/0", perf_fetched, perf_stall); end
        reset = 1'b0; out_ready = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_boot_sequence();
        test_backpressure();
        test_redirect();
        test_fault_end();
        test_fault_recovery();
        test_boot_redirect_and_midreset();
`ifdef FETCH_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
